// File: rtl/switch_event_arbiter_pkg.sv
// Shared types and helpers for the switch event arbiter slice.
package switch_event_pkg;

  typedef enum logic [1:0] {INIT, IDLE, OFFER} arb_state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/switch_event_arbiter_if.sv
// Event channel between the arbiter (master) and a consumer (slave).
interface switch_event_arbiter_if #(
  parameter int unsigned input_count = 16
);
  logic                                                 event_valid;
  logic                                                 event_ready;
  logic [switch_event_pkg::idx_width(input_count)-1:0] event_index;
  logic                                                 event_level;

  modport master (output event_valid, event_index, event_level, input event_ready);
  modport slave  (input event_valid, event_index, event_level, output event_ready);
endinterface

// File: rtl/switch_event_arbiter_rr_priority_select.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_priority_select
  import switch_event_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0]              req,
  input  logic [idx_width(N)-1:0]   ptr,
  output logic                      any,
  output logic [idx_width(N)-1:0]   grant_idx
);
  localparam int unsigned W  = idx_width(N);
  localparam int unsigned SW = W + 1;

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W-1:0]   first;
  logic [SW-1:0]  sum;

  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[N-1:0];
    any   = |req;
    first = '0;
    // Descending scan so the lowest rotated position is the one kept.
    for (int unsigned i = N; i > 0; i--) begin
      if (rot[i-1]) first = W'(i - 1);
    end
    sum = {1'b0, first} + {1'b0, ptr};
    if (sum >= SW'(N)) sum = sum - SW'(N);
    grant_idx = sum[W-1:0];
  end
endmodule

// File: rtl/switch_event_arbiter.sv
// Turns debounced switch level changes into queued events served round-robin
// over a single valid/ready channel, counting overwritten events.
module switch_event_arbiter
  import switch_event_pkg::*;
#(
  parameter int unsigned input_count   = 16,
  parameter int unsigned overrun_width = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [input_count-1:0]    switch_state,
  input  logic                      overrun_clear,
  switch_event_arbiter_if.master    ev,
  output logic [input_count-1:0]    pending,
  output logic [overrun_width-1:0]  overrun_count
);
  localparam int unsigned IW = idx_width(input_count);
  localparam int unsigned CW = IW + 1;
  localparam int unsigned SW = overrun_width + CW + 1;

  arb_state_t             state;
  logic [input_count-1:0] prev;
  logic [input_count-1:0] pend_level;
  logic [IW-1:0]          rr_ptr;

  logic                   any;
  logic [IW-1:0]          grant_idx;
  logic [input_count-1:0] edges;
  logic [input_count-1:0] clr;
  logic [input_count-1:0] ovr_mask;
  logic [CW-1:0]          ovr_hits;
  logic [SW-1:0]          ovr_sum;
  logic [overrun_width-1:0] ovr_next;

  rr_priority_select #(.N(input_count)) u_select (
    .req       (pending),
    .ptr       (rr_ptr),
    .any       (any),
    .grant_idx (grant_idx)
  );

  always_comb begin
    edges = (state == INIT) ? '0 : (switch_state ^ prev);
    clr   = '0;
    if (state == IDLE && any) clr[grant_idx] = 1'b1;
    // The bit being latched this cycle is not an overrun if it toggles again.
    ovr_mask = edges & pending & ~clr;
    ovr_hits = '0;
    for (int unsigned i = 0; i < input_count; i++) begin
      ovr_hits = ovr_hits + CW'(ovr_mask[i]);
    end
    ovr_sum  = SW'(overrun_count) + SW'(ovr_hits);
    ovr_next = (ovr_sum > SW'({overrun_width{1'b1}})) ? '1 : ovr_sum[overrun_width-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= INIT;
      prev           <= '0;
      pending        <= '0;
      pend_level     <= '0;
      rr_ptr         <= '0;
      overrun_count  <= '0;
      ev.event_valid <= 1'b0;
      ev.event_index <= '0;
      ev.event_level <= 1'b0;
    end else begin
      prev          <= switch_state;
      pending       <= (pending & ~clr) | edges;
      pend_level    <= (pend_level & ~edges) | (switch_state & edges);
      overrun_count <= overrun_clear ? '0 : ovr_next;
      case (state)
        INIT: state <= IDLE;
        IDLE: begin
          if (any) begin
            ev.event_index <= grant_idx;
            ev.event_level <= pend_level[grant_idx];
            ev.event_valid <= 1'b1;
            state          <= OFFER;
          end
        end
        OFFER: begin
          if (ev.event_ready) begin
            rr_ptr         <= (ev.event_index == IW'(input_count - 1)) ? '0
                                                                       : ev.event_index + IW'(1);
            ev.event_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_switch_event_arbiter.sv
// Directed bench for switch_event_arbiter with hand-computed expectations.
module tb_switch_event_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sw = '0;
  logic        clr = 1'b0;
  logic [15:0] pending;
  logic [7:0]  overrun_count;

  logic [15:0] sw2 = '0;
  logic        clr2 = 1'b0;
  logic [15:0] pending2;
  logic [1:0]  overrun_count2;

  int n_checks = 0;
  int n_errors = 0;

  switch_event_arbiter_if #(.input_count(16)) ev ();
  switch_event_arbiter_if #(.input_count(16)) ev2 ();

  switch_event_arbiter #(.input_count(16), .overrun_width(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .switch_state  (sw),
    .overrun_clear (clr),
    .ev            (ev.master),
    .pending       (pending),
    .overrun_count (overrun_count)
  );

  switch_event_arbiter #(.input_count(16), .overrun_width(2)) dut_sat (
    .clk           (clk),
    .reset         (reset),
    .switch_state  (sw2),
    .overrun_clear (clr2),
    .ev            (ev2.master),
    .pending       (pending2),
    .overrun_count (overrun_count2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] init_sw);
    sw    = init_sw;
    sw2   = '0;
    clr   = 1'b0;
    reset = 1'b1;
    step();
    step();
    check("rst_valid", ev.event_valid, 0);
    check("rst_index", ev.event_index, 0);
    check("rst_level", ev.event_level, 0);
    check("rst_pending", pending, 0);
    check("rst_overrun", overrun_count, 0);
    reset = 1'b0;
    step();
  endtask

  task automatic expect_event(input string tag, input int idx, input logic lvl);
    int n = 0;
    step();
    while (!ev.event_valid && n < 8) begin
      step();
      n++;
    end
    check({tag, "_valid"}, ev.event_valid, 1);
    check({tag, "_idx"}, ev.event_index, idx);
    check({tag, "_lvl"}, ev.event_level, lvl);
  endtask

  initial begin
    logic seen;
    ev.event_ready  = 1'b0;
    ev2.event_ready = 1'b0;

    // Power-up switch positions must not generate events.
    do_reset(16'h00F0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      seen = seen | ev.event_valid;
    end
    check("t1_no_event", seen, 0);
    check("t1_pending", pending, 0);

    // Single edge latency.
    ev.event_ready = 1'b1;
    sw = 16'h00F8;
    step();
    check("t2_valid_t1", ev.event_valid, 0);
    check("t2_pend_t1", pending, 16'h0008);
    step();
    check("t2_valid_t2", ev.event_valid, 1);
    check("t2_idx", ev.event_index, 3);
    check("t2_lvl", ev.event_level, 1);
    check("t2_pend_t2", pending, 0);
    step();
    check("t2_valid_t3", ev.event_valid, 0);

    // Round-robin order.
    do_reset(16'h0000);
    ev.event_ready = 1'b1;
    sw = 16'h8001;
    expect_event("t3a", 0, 1);
    expect_event("t3b", 15, 1);
    sw = 16'h0000;
    expect_event("t3c", 0, 0);
    expect_event("t3d", 15, 0);
    sw = 16'h0003;
    expect_event("t3e", 0, 1);
    expect_event("t3f", 1, 1);
    sw = 16'h0002;
    expect_event("t3g", 0, 0);
    sw = 16'h0001;
    expect_event("t3h", 1, 0);
    expect_event("t3i", 0, 1);

    // Overrun counting, clear priority, offered-bit and set-wins cases.
    do_reset(16'h0000);
    ev.event_ready = 1'b0;
    sw = 16'h0004;
    step();
    step();
    check("t4_offer_valid", ev.event_valid, 1);
    check("t4_offer_idx", ev.event_index, 2);
    sw = 16'h0024;
    step();
    check("t4_ovr0", overrun_count, 0);
    sw = 16'h0004;
    step();
    check("t4_ovr1", overrun_count, 1);
    sw = 16'h0024;
    step();
    check("t4_ovr2", overrun_count, 2);
    check("t4_pend5", pending, 16'h0020);
    clr = 1'b1;
    sw  = 16'h0004;
    step();
    clr = 1'b0;
    check("t4_clr_prio", overrun_count, 0);
    sw = 16'h0000;
    step();
    check("t4_offered_edge_pend", pending, 16'h0024);
    check("t4_offered_edge_ovr", overrun_count, 0);
    check("t4_still_idx", ev.event_index, 2);
    check("t4_still_lvl", ev.event_level, 1);
    ev.event_ready = 1'b1;
    expect_event("t4a", 5, 0);
    expect_event("t4b", 2, 0);
    sw = 16'h0040;
    step();
    check("t4_setwin_pre", pending, 16'h0040);
    sw = 16'h0000;
    step();
    check("t4_setwin_valid", ev.event_valid, 1);
    check("t4_setwin_idx", ev.event_index, 6);
    check("t4_setwin_lvl", ev.event_level, 1);
    check("t4_setwin_pend", pending, 16'h0040);
    check("t4_setwin_ovr", overrun_count, 0);
    expect_event("t4c", 6, 0);

    // Saturation with a 2-bit counter, including simultaneous overruns.
    do_reset(16'h0000);
    sw2 = 16'h0001;
    step();
    step();
    check("t5_offer", ev2.event_valid, 1);
    sw2 = 16'h0007;
    step();
    check("t5_pend", pending2, 16'h0006);
    sw2 = 16'h0001;
    step();
    check("t5_ovr_multi", overrun_count2, 2);
    sw2 = 16'h0007;
    step();
    check("t5_ovr_sat", overrun_count2, 3);
    sw2 = 16'h0001;
    step();
    check("t5_ovr_hold", overrun_count2, 3);

    // Asynchronous reset with events outstanding.
    do_reset(16'h0000);
    ev.event_ready = 1'b0;
    sw = 16'h0001;
    step();
    step();
    sw = 16'h001F;
    step();
    check("t6_pre_valid", ev.event_valid, 1);
    check("t6_pre_pend", pending, 16'h001E);
    #2 reset = 1'b1;
    #1;
    check("t6_async_valid", ev.event_valid, 0);
    check("t6_async_pend", pending, 0);
    check("t6_async_idx", ev.event_index, 0);
    #2 reset = 1'b0;
    ev.event_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen = seen | ev.event_valid;
    end
    check("t6_no_event", seen, 0);
    check("t6_pending", pending, 0);
    sw = 16'h009F;
    expect_event("t6_fresh", 7, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
